dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Round-robin arbiter that shares one `dpram_rw` instance between `NUM_REQ` requesters. Each requester issues single-word read or write commands on a valid/ready handshake. The read and write ports of the RAM are arbitrated independently, so the block can accept one read and one write per cycle. Read data returns on a shared response bus with a one-hot valid. The block sits between client engines (DMA, CPU shim) and the RAM and owns the only `dpram_rw` instance.

## Interface
- `DATA_WIDTH`, 8: word width.
- `DATA_DEPTH`, 256: words; power of two; `AW = $clog2(DATA_DEPTH)`.
- `NUM_REQ`, 2: requesters, 2..8.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: command valid per requester.
- `req_ready` out NUM_REQ: command accepted this cycle (valid && ready at posedge).
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*AW: word address, requester i at bits [i*AW +: AW].
- `req_wdata` in NUM_REQ*DATA_WIDTH: write data, packed the same way.
- `rsp_valid` out NUM_REQ: one-hot; read data for requester i is on `rsp_data`.
- `rsp_data` out DATA_WIDTH: read response data.

## Operation
- Each requester is classified per cycle as a read candidate (`valid && !we`) or a write candidate (`valid && we`). A requester holds at most one command per cycle.
- Read port and write port each have an independent round-robin arbiter over their candidates.
- Each arbiter has a priority pointer `ptr`. The winner is the first candidate at or after `ptr`, scanning modulo NUM_REQ. On a grant, `ptr` becomes winner+1 (mod NUM_REQ). With no grant, `ptr` holds.
- `req_ready[i]` is combinational: 1 iff i is the read winner or the write winner. It may depend on `req_valid` and `req_we`; the interface allows this.
- Granted write drives RAM `wr_en=1`, `wr_addr`, `wr_data` from the winner.
- Granted read drives RAM `rd_en=1`, `rd_addr` from the winner. The winner index is registered as the response tag.
- With no read grant, `rd_en=0` and the RAM `rd_data` holds its value. `rsp_data` therefore holds its last value; it is meaningful only while `rsp_valid` is set.
- Read and write to the same address accepted in the same cycle: the RAM is read-first, so the response carries the old data unless the bypass is compiled in (see Configuration).

## Timing
- Reset values: `rsp_valid=0`, both `ptr=0`, tag register 0, RAM enables 0. `req_ready` is 0 whenever `rst` is high.
- Read latency 1: a read accepted at posedge N gives `rsp_valid[tag]=1` and valid `rsp_data` for exactly the cycle after posedge N. Back-to-back reads give back-to-back responses.
- A write accepted at posedge N is visible to any read accepted at posedge N+1 or later.
- Throughput: 1 read + 1 write per cycle in aggregate. A single requester gets at most 1 command per cycle.
- Fairness: a requester with a continuously pending read waits at most NUM_REQ-1 read grants. The same bound applies to writes.
- Reset mid-operation: an in-flight read response is dropped (`rsp_valid=0` after the reset edge) and pointers return to 0. RAM contents are not defined by this block.
- All requesters idle: no RAM enables asserted, pointers unchanged.

## Configuration
- `DPRAM_ARBITER_BYPASS_EN` defined:
  - When the read and write grants in the same cycle target the same address, the arbiter registers the write data and a bypass flag.
  - The response then returns the new write data instead of RAM `rd_data`.
  - Adds a DATA_WIDTH register and a 1-bit flag.
- Undefined: response returns RAM `rd_data`, which is the old contents (read-first).

## Structure
- Package `dpram_arbiter_pkg`: `rr_ptr_t` (logic [$clog2(NUM_REQ_MAX)-1:0]), `NUM_REQ_MAX = 8`, and a `cmd_t` struct {we, addr, wdata} used by benches.
- Sub-module `rr_arbiter`:
  - Parameters `N`.
  - Inputs `clk`, `rst`, `req[N]`.
  - Outputs `gnt[N]` (one-hot, combinational) and `gnt_valid`.
  - Owns its pointer.
  - Instantiated twice: read port and write port.
- `dpram_rw` is instantiated once inside.

## Test plan
- Single requester: write 0..3 = de/ad/be/ef, then read 0..3 → `rsp_valid[0]` one cycle after each accept, data de/ad/be/ef.
- Contention, NUM_REQ=2: both hold write requests (req0 addr 5 = 0x11, req1 addr 6 = 0x22) → grants alternate 0,1,0,1. Neither starves; reads back return 0x11/0x22.
- Mixed: req0 reads addr 5 while req1 writes addr 7 = 0x77, same cycle → both `req_ready` high. `rsp_valid=2'b01` next cycle with 0x11.
- Same-address collision: addr 128 = 0xff; req0 reads 128 while req1 writes 0x5a → response 0xff without the macro, 0x5a with it. A subsequent read returns 0x5a in both builds.
- Read-disable: after a read of 0 (0xde), no requests for 20 cycles while addresses toggle → `rsp_valid=0` throughout and `rsp_data` stays 0xde.
- Reset mid-read: read accepted, `rst` asserted the next cycle → `rsp_valid` 0 after the reset edge. After release, the first contended grant goes to requester 0.

Source files
------------

// File: rtl/dpram_arbiter_pkg.sv
// Shared types for dpram_arbiter: round-robin pointer type, requester limit and a bench command record.
// Optional build macro used by the top: DPRAM_ARBITER_BYPASS_EN.
package dpram_arbiter_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned PTR_W       = $clog2(NUM_REQ_MAX);
    localparam int unsigned CMD_AW      = 8;
    localparam int unsigned CMD_DW      = 8;

    typedef logic [PTR_W-1:0] rr_ptr_t;

    typedef struct packed {
        logic              we;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
    } cmd_t;

    // Advance a round-robin index by one, wrapping at n.
    function automatic rr_ptr_t rr_next(input rr_ptr_t idx, input int unsigned n);
        return (idx == rr_ptr_t'(n - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/dpram_rw.sv
// Simple dual-port RAM: one write port, one read-first read port; read data holds when rd_en_i is low.
module dpram_rw #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_DEPTH = 256,
    localparam int unsigned AW        = $clog2(DATA_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, then moves the pointer past it.
module rr_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         gnt_valid_o
);

    rr_ptr_t ptr_q, ptr_d;
    rr_ptr_t hi_win, lo_win, win;
    logic    hi_found, lo_found;

    // Descending scan leaves the lowest index set: lowest at/after ptr, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_found = 1'b1;
                lo_win   = rr_ptr_t'(i);
                if (rr_ptr_t'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = rr_ptr_t'(i);
                end
            end
        end
        win         = hi_found ? hi_win : lo_win;
        gnt_valid_o = hi_found | lo_found;
        for (int i = 0; i < int'(N); i++) begin
            gnt_o[i] = gnt_valid_o && (win == rr_ptr_t'(i));
        end
        ptr_d = gnt_valid_o ? rr_next(win, N) : ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dpram_rw between NUM_REQ requesters with independent round-robin read and write ports.
// Define DPRAM_ARBITER_BYPASS_EN to return same-cycle write data on a read/write address collision.
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_DEPTH = 256,
    parameter int unsigned NUM_REQ    = 2,
    localparam int unsigned AW        = $clog2(DATA_DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*AW-1:0]         req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    rd_cand, wr_cand, rd_gnt, wr_gnt;
    logic                  rd_gv, wr_gv, rd_fire, wr_fire;
    logic [IW-1:0]         rd_idx;
    logic [AW-1:0]         rd_addr, wr_addr;
    logic [DATA_WIDTH-1:0] wr_data, ram_rd_data;
    logic [IW-1:0]         tag_q, tag_d;
    logic                  rsp_valid_q, rsp_valid_d;

    assign rd_cand = req_valid_i & ~req_we_i;
    assign wr_cand = req_valid_i & req_we_i;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rd_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (rd_cand),
        .gnt_o       (rd_gnt),
        .gnt_valid_o (rd_gv)
    );

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_wr_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (wr_cand),
        .gnt_o       (wr_gnt),
        .gnt_valid_o (wr_gv)
    );

    always_comb begin
        rd_idx  = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rd_gnt[i]) begin
                rd_idx  = IW'(i);
                rd_addr = req_addr_i[i*AW +: AW];
            end
            if (wr_gnt[i]) begin
                wr_addr = req_addr_i[i*AW +: AW];
                wr_data = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_fire     = rd_gv & ~rst_i;
    assign wr_fire     = wr_gv & ~rst_i;
    assign req_ready_o = rst_i ? '0 : (rd_gnt | wr_gnt);

    dpram_rw #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_fire),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rd_data)
    );

    always_comb begin
        rsp_valid_d = rd_fire;
        tag_d       = rd_fire ? rd_idx : tag_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            tag_q       <= tag_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_valid_o[i] = rsp_valid_q && (tag_q == IW'(i));
        end
    end

`ifdef DPRAM_ARBITER_BYPASS_EN
    logic                  byp_q, byp_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

    // Only refreshed on a read grant so rsp_data_o holds between responses.
    always_comb begin
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        if (rd_fire) begin
            byp_d      = wr_fire && (wr_addr == rd_addr);
            byp_data_d = wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign rsp_data_o = byp_q ? byp_data_q : ram_rd_data;
`else
    assign rsp_data_o = ram_rd_data;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Self-checking bench for dpram_arbiter: directed vector table, then random traffic against a reference model.
module tb_dpram_arbiter;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

`ifdef DPRAM_ARBITER_BYPASS_EN
    localparam logic [7:0] COLL = 8'h5a;
    localparam bit         BYP  = 1'b1;
`else
    localparam logic [7:0] COLL = 8'hff;
    localparam bit         BYP  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid = '0, we = '0, ready, rsp_valid;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [DW-1:0]   rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dpram_arbiter #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .NUM_REQ    (N)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_we_i    (we),
        .req_addr_i  (addr),
        .req_wdata_i (wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data)
    );

    // Reference model: pointers as ints, memory as an array with a written flag per word.
    int            m_rptr = 0, m_wptr = 0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    logic [N-1:0]  m_rv = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_data_known = 1'b0;

    function automatic int pick(input logic [N-1:0] c, input int p);
        for (int k = 0; k < N; k++) begin
            int i = (p + k) % N;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        int rw, ww;
        if (rst) return '0;
        rw = pick(valid & ~we, m_rptr);
        ww = pick(valid & we, m_wptr);
        if (rw >= 0) r[rw] = 1'b1;
        if (ww >= 0) r[ww] = 1'b1;
        return r;
    endfunction

    task automatic model_update();
        int rw, ww, ra, wa;
        if (rst) begin
            m_rptr = 0;
            m_wptr = 0;
            m_rv = '0;
            m_data_known = 1'b0;
            return;
        end
        rw = pick(valid & ~we, m_rptr);
        ww = pick(valid & we, m_wptr);
        wa = (ww >= 0) ? int'(addr[ww*AW +: AW]) : -1;
        if (rw >= 0) begin
            ra = int'(addr[rw*AW +: AW]);
            m_rv = '0;
            m_rv[rw] = 1'b1;
            if (BYP && ww >= 0 && wa == ra) begin
                m_data = wdata[ww*DW +: DW];
                m_data_known = 1'b1;
            end else begin
                m_data = m_mem[ra];
                m_data_known = m_known[ra];
            end
            m_rptr = (rw + 1) % N;
        end else begin
            m_rv = '0;
        end
        if (ww >= 0) begin
            m_mem[wa] = wdata[ww*DW +: DW];
            m_known[wa] = 1'b1;
            m_wptr = (ww + 1) % N;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       r;
        logic [1:0] v, w;
        logic [7:0] a0, a1, d0, d1;
        logic [1:0] er;
        logic       cv;
        logic [1:0] ev;
        logic       cd;
        logic [7:0] ed;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] v, logic [1:0] w, logic [7:0] a0,
                                logic [7:0] a1, logic [7:0] d0, logic [7:0] d1, logic [1:0] er,
                                logic cv, logic [1:0] ev, logic cd, logic [7:0] ed);
        vec_t t;
        t.r = r;   t.v = v;   t.w = w;   t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.er = er; t.cv = cv; t.ev = ev; t.cd = cd; t.ed = ed;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset, then single-requester writes and reads.
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b01, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 8'hde, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 8'had, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2, 0, 8'hbe, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 3, 0, 8'hef, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 0, 0, 2'b01, 1, 2'b01, 1, 8'hde));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2, 0, 0, 0, 2'b01, 1, 2'b01, 1, 8'had));
        tbl.push_back(mk(0, 2'b01, 2'b00, 3, 0, 0, 0, 2'b01, 1, 2'b01, 1, 8'hbe));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 8'hef));
        // Write contention: write pointer sits at 1, so grants alternate 1,0,1,0.
        tbl.push_back(mk(0, 2'b11, 2'b11, 5, 6, 8'h11, 8'h22, 2'b10, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 5, 6, 8'h11, 8'h22, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 5, 6, 8'h11, 8'h22, 2'b10, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 5, 6, 8'h11, 8'h22, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 5, 6, 0, 0, 2'b10, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 5, 6, 0, 0, 2'b01, 1, 2'b10, 1, 8'h22));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 8'h11));
        // Mixed read and write in one cycle.
        tbl.push_back(mk(0, 2'b11, 2'b10, 5, 7, 0, 8'h77, 2'b11, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 8'h11));
        // Same-address collision at 128.
        tbl.push_back(mk(0, 2'b01, 2'b01, 128, 0, 8'hff, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b10, 128, 128, 0, 8'h5a, 2'b11, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 128, 0, 0, 0, 2'b01, 1, 2'b01, 1, COLL));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 8'h5a));
        // Read disabled: data holds while addresses toggle.
        tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0));
        for (int i = 0; i < 20; i++) begin
            tbl.push_back(mk(0, 2'b00, 2'b00, 8'(i), ~8'(i), 8'(i * 3), 8'(i * 5), 2'b00, 1,
                             (i == 0) ? 2'b01 : 2'b00, 1, 8'hde));
        end
        // Reset during an in-flight read; read pointer must come back to 0.
        tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 8'hde));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, 2, 0, 0, 2'b01, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 8'had));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r;
            valid = tbl[i].v;
            we = tbl[i].w;
            addr = {tbl[i].a1, tbl[i].a0};
            wdata = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("vec%0d ready", i), 32'(ready), 32'(tbl[i].er));
            if (tbl[i].cv) chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].ev));
            if (tbl[i].cd) chk($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(tbl[i].ed));
            model_update();
        end

        // Random traffic on a small address window to force collisions.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            valid = N'($urandom);
            we = N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                wdata[i*DW +: DW] = DW'($urandom);
            end
            #1;
            chk($sformatf("rnd%0d rsp_valid", c), 32'(rsp_valid), 32'(m_rv));
            if (m_data_known) chk($sformatf("rnd%0d rsp_data", c), 32'(rsp_data), 32'(m_data));
            chk($sformatf("rnd%0d ready", c), 32'(ready), 32'(model_ready()));
            model_update();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
